// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit:
// opcodes, FSM states and flag bit positions.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_NOR = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_ROR = 3'd5;
  localparam logic [2:0] OP_POP = 3'd6;
  localparam logic [2:0] OP_ABS = 3'd7;

  localparam int FLAG_CARRY = 1;
  localparam int FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_regfile.sv
// 4xN register file, R0 reads as zero.
// Ports: rd_a/rd_b/dbg read ports, one write port (we, wr_idx, wr_data).
module alu_regfile #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   rd_a_idx,
  output logic [N-1:0] rd_a,
  input  logic [1:0]   rd_b_idx,
  output logic [N-1:0] rd_b,
  input  logic [1:0]   dbg_idx,
  output logic [N-1:0] dbg_data,
  input  logic         we,
  input  logic [1:0]   wr_idx,
  input  logic [N-1:0] wr_data
);

  logic [N-1:0] r1;
  logic [N-1:0] r2;
  logic [N-1:0] r3;

  function automatic logic [N-1:0] rd(
    input logic [1:0]   idx,
    input logic [N-1:0] v1,
    input logic [N-1:0] v2,
    input logic [N-1:0] v3
  );
    logic [N-1:0] v;
    v = '0;
    unique case (idx)
      2'd1:    v = v1;
      2'd2:    v = v2;
      2'd3:    v = v3;
      default: v = '0;
    endcase
    return v;
  endfunction

  assign rd_a     = rd(rd_a_idx, r1, r2, r3);
  assign rd_b     = rd(rd_b_idx, r1, r2, r3);
  assign dbg_data = rd(dbg_idx, r1, r2, r3);

  // Writes to index 0 fall through and are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else if (we) begin
      unique case (wr_idx)
        2'd1:    r1 <= wr_data;
        2'd2:    r2 <= wr_data;
        2'd3:    r3 <= wr_data;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issue stage in front of the combinational ALU: one command in flight,
// cmd handshake -> operand read -> ALU -> writeback -> res handshake.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int N     = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [1:0]       cmd_dst,
  input  logic [1:0]       cmd_srca,
  input  logic [1:0]       cmd_srcb,
  input  logic             cmd_imm_en,
  input  logic [N-1:0]     cmd_imm,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic [2:0]       alu_opcode,
  input  logic [N-1:0]     alu_result,
  input  logic [1:0]       alu_flags,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic [1:0]       res_flags,
  output logic [1:0]       res_dst,
  output logic             sticky_carry,
  input  logic             sticky_clr,
  output logic [CNT_W-1:0] op_count,
  input  logic [1:0]       dbg_sel,
  output logic [N-1:0]     dbg_data
);

  state_t       state;
  logic [1:0]   dst_q;
  logic [N-1:0] rd_a;
  logic [N-1:0] rd_b;
  logic         we;

  assign we = (state == ST_EXEC);

  alu_regfile #(.N(N)) u_rf (
    .clk      (clk),
    .rst_n    (rst_n),
    .rd_a_idx (cmd_srca),
    .rd_a     (rd_a),
    .rd_b_idx (cmd_srcb),
    .rd_b     (rd_b),
    .dbg_idx  (dbg_sel),
    .dbg_data (dbg_data),
    .we       (we),
    .wr_idx   (dst_q),
    .wr_data  (alu_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      cmd_ready    <= 1'b1;
      dst_q        <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      alu_opcode   <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      res_flags    <= '0;
      res_dst      <= '0;
      sticky_carry <= 1'b0;
      op_count     <= '0;
    end else begin
      if (sticky_clr) sticky_carry <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            alu_a      <= rd_a;
            alu_b      <= cmd_imm_en ? cmd_imm : rd_b;
            alu_opcode <= cmd_op;
            dst_q      <= cmd_dst;
            cmd_ready  <= 1'b0;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          res_data  <= alu_result;
          res_flags <= alu_flags;
          res_dst   <= dst_q;
          // Clear beats a simultaneous carry capture.
          sticky_carry <= !sticky_clr &&
                          (sticky_carry || alu_flags[FLAG_CARRY]);
          res_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            op_count  <= op_count + CNT_W'(1);
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          cmd_ready <= 1'b1;
          res_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit with a behavioural ALU.
// Table-driven command vectors plus directed multi-cycle sequences.
module tb_alu_issue_unit;
  import alu_pkg::*;

  localparam int N     = 8;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [1:0]       cmd_dst;
  logic [1:0]       cmd_srca;
  logic [1:0]       cmd_srcb;
  logic             cmd_imm_en;
  logic [N-1:0]     cmd_imm;
  logic [N-1:0]     alu_a;
  logic [N-1:0]     alu_b;
  logic [2:0]       alu_opcode;
  logic [N-1:0]     alu_result;
  logic [1:0]       alu_flags;
  logic             res_valid;
  logic             res_ready;
  logic [N-1:0]     res_data;
  logic [1:0]       res_flags;
  logic [1:0]       res_dst;
  logic             sticky_carry;
  logic             sticky_clr;
  logic [CNT_W-1:0] op_count;
  logic [1:0]       dbg_sel;
  logic [N-1:0]     dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(.N(N), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_dst      (cmd_dst),
    .cmd_srca     (cmd_srca),
    .cmd_srcb     (cmd_srcb),
    .cmd_imm_en   (cmd_imm_en),
    .cmd_imm      (cmd_imm),
    .alu_a        (alu_a),
    .alu_b        (alu_b),
    .alu_opcode   (alu_opcode),
    .alu_result   (alu_result),
    .alu_flags    (alu_flags),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .res_flags    (res_flags),
    .res_dst      (res_dst),
    .sticky_carry (sticky_carry),
    .sticky_clr   (sticky_clr),
    .op_count     (op_count),
    .dbg_sel      (dbg_sel),
    .dbg_data     (dbg_data)
  );

  // Behavioural ALU; carry on SUB means borrow (a < b).
  logic [N:0]   t9;
  logic [15:0]  rr;
  always_comb begin
    t9 = '0;
    rr = {alu_a, alu_a} >> alu_b[2:0];
    case (alu_opcode)
      OP_ADD: t9 = {1'b0, alu_a} + {1'b0, alu_b};
      OP_SUB: t9 = {1'b0, alu_a} - {1'b0, alu_b};
      OP_AND: t9 = {1'b0, alu_a & alu_b};
      OP_NOR: t9 = {1'b0, ~(alu_a | alu_b)};
      OP_XOR: t9 = {1'b0, alu_a ^ alu_b};
      OP_ROR: t9 = {1'b0, rr[7:0]};
      OP_POP: t9 = 9'($countones(alu_a))
                 + 9'($countones(alu_b));
      default: t9 = {1'b0,
                     alu_b[7] ? (~alu_b + 8'd1) : alu_b};
    endcase
    alu_result = t9[7:0];
    alu_flags  = {t9[8], t9[7:0] == 8'd0};
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Drive one command; returns at the negedge after acceptance.
  task automatic send(input logic [2:0] op, input logic [1:0] d,
                      input logic [1:0] sa, input logic [1:0] sb,
                      input logic ie, input logic [7:0] imm);
    int n;
    n = 0;
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_dst    = d;
    cmd_srca   = sa;
    cmd_srcb   = sb;
    cmd_imm_en = ie;
    cmd_imm    = imm;
    @(negedge clk);
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_res();
    int n;
    n = 0;
    while (!res_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("res_valid_timeout", 32'(res_valid), 32'd1);
  endtask

  typedef struct {
    logic [2:0] op;
    logic [1:0] d;
    logic [1:0] sa;
    logic [1:0] sb;
    logic       ie;
    logic [7:0] imm;
    logic [7:0] ed;
    logic [1:0] ef;
    logic [7:0] er;
  } vec_t;

  vec_t tv[11];

  initial begin
    tv[0]  = '{OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h05, 8'h05, 2'b00, 8'h05};
    tv[1]  = '{OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hFB, 8'h00, 2'b11, 8'h00};
    tv[2]  = '{OP_ADD, 2'd0, 2'd0, 2'd0, 1'b1, 8'h7F, 8'h7F, 2'b00, 8'h00};
    tv[3]  = '{OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h81, 8'h81, 2'b00, 8'h81};
    tv[4]  = '{OP_ROR, 2'd3, 2'd1, 2'd0, 1'b1, 8'h01, 8'hC0, 2'b00, 8'hC0};
    tv[5]  = '{OP_POP, 2'd2, 2'd3, 2'd1, 1'b0, 8'h00, 8'h04, 2'b00, 8'h04};
    tv[6]  = '{OP_SUB, 2'd1, 2'd2, 2'd0, 1'b1, 8'h04, 8'h00, 2'b01, 8'h00};
    tv[7]  = '{OP_AND, 2'd1, 2'd3, 2'd2, 1'b0, 8'h00, 8'h00, 2'b01, 8'h00};
    tv[8]  = '{OP_XOR, 2'd1, 2'd3, 2'd0, 1'b1, 8'hFF, 8'h3F, 2'b00, 8'h3F};
    tv[9]  = '{OP_NOR, 2'd2, 2'd1, 2'd0, 1'b1, 8'h00, 8'hC0, 2'b00, 8'hC0};
    tv[10] = '{OP_ABS, 2'd3, 2'd0, 2'd0, 1'b1, 8'h85, 8'h7B, 2'b00, 8'h7B};

    rst_n = 1'b0;
    cmd_valid = 1'b0;
    cmd_op = '0;
    cmd_dst = '0;
    cmd_srca = '0;
    cmd_srcb = '0;
    cmd_imm_en = 1'b0;
    cmd_imm = '0;
    res_ready = 1'b1;
    sticky_clr = 1'b0;
    dbg_sel = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_sticky", 32'(sticky_carry), 32'd0);
    chk("rst_alu_a", 32'(alu_a), 32'd0);

    for (int i = 0; i < 11; i++) begin
      send(tv[i].op, tv[i].d, tv[i].sa, tv[i].sb, tv[i].ie, tv[i].imm);
      wait_res();
      chk($sformatf("v%0d_data", i), 32'(res_data), 32'(tv[i].ed));
      chk($sformatf("v%0d_flags", i), 32'(res_flags), 32'(tv[i].ef));
      chk($sformatf("v%0d_dst", i), 32'(res_dst), 32'(tv[i].d));
      dbg_sel = tv[i].d;
      #1;
      chk($sformatf("v%0d_reg", i), 32'(dbg_data), 32'(tv[i].er));
      @(negedge clk);
      chk($sformatf("v%0d_hs", i), 32'(res_valid), 32'd0);
    end
    chk("tbl_op_count", 32'(op_count), 32'd11);
    chk("tbl_sticky", 32'(sticky_carry), 32'd1);

    // Backpressure; also dbg shows the old R1 during EXEC.
    res_ready = 1'b0;
    dbg_sel = 2'd1;
    send(OP_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10);
    chk("exec_dbg_old", 32'(dbg_data), 32'h3F);
    wait_res();
    for (int i = 0; i < 5; i++) begin
      chk("bp_data", 32'(res_data), 32'h10);
      chk("bp_valid", 32'(res_valid), 32'd1);
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_count", 32'(op_count), 32'd11);
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_count_inc", 32'(op_count), 32'd12);
    chk("bp_valid_low", 32'(res_valid), 32'd0);
    chk("bp_cmd_ready_up", 32'(cmd_ready), 32'd1);
    chk("bp_r1", 32'(dbg_data), 32'h10);

    // Plain sticky clear.
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("sticky_clr", 32'(sticky_carry), 32'd0);

    // Clear on the same edge as a carry capture.
    send(OP_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 8'hF0);
    sticky_clr = 1'b1;
    @(negedge clk);
    sticky_clr = 1'b0;
    chk("coll_flags", 32'(res_flags), 32'd3);
    chk("coll_sticky", 32'(sticky_carry), 32'd0);
    @(negedge clk);
    send(OP_ADD, 2'd3, 2'd1, 2'd0, 1'b1, 8'hF1);
    wait_res();
    chk("carry_data", 32'(res_data), 32'h01);
    chk("carry_sticky", 32'(sticky_carry), 32'd1);
    @(negedge clk);

    // Reset while in EXEC.
    send(OP_ADD, 2'd3, 2'd0, 2'd0, 1'b1, 8'h55);
    rst_n = 1'b0;
    #1;
    chk("mrst_valid", 32'(res_valid), 32'd0);
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_count", 32'(op_count), 32'd0);
    chk("mrst_sticky", 32'(sticky_carry), 32'd0);
    chk("mrst_alu_b", 32'(alu_b), 32'd0);
    for (int r = 0; r < 4; r++) begin
      dbg_sel = 2'(r);
      #1;
      chk($sformatf("mrst_r%0d", r), 32'(dbg_data), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    dbg_sel = 2'd3;
    #1;
    chk("post_rst_r3", 32'(dbg_data), 32'd0);
    chk("post_rst_valid", 32'(res_valid), 32'd0);
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
